player_sprite_render: RTL and testbench
=======================================

# player_sprite_render

Downstream consumer of player 1's 10-bit X-position PIO register: converts the software-written X coordinate into per-pixel sprite coverage for the VGA output path. It double-buffers the position at frame boundaries so a mid-frame CPU write never tears the sprite. It tests each incoming pixel coordinate against the player rectangle, and emits a 2-cycle-latency pixel stream (on-flag plus colour) to the pixel mixer.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- SPRITE_W, 32, sprite width in pixels
- SPRITE_H, 16, sprite height in lines
- Y_POS, 448, fixed top line of the player sprite
- COLOR, 12'hF80, sprite colour (RGB 4:4:4)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- x_pos  in  10  player X from the PIO output port, same clock domain
- frame_start  in  1  one-cycle pulse, frame boundary (vblank)
- pix_valid  in  1  pix_x/pix_y qualify this cycle
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel line
- out_valid  out  1  output pixel qualifier
- out_on  out  1  pixel lies inside sprite
- out_x  out  10  pixel column, delayed
- out_y  out  10  pixel line, delayed
- out_color  out  12  COLOR when out_on, else 0
- pos_latched  out  10  position used for the current frame
- moved  out  1  one-cycle pulse: latched position changed at the frame boundary

## Operation
- Shadow register `pos_latched` loads x_pos (after optional clamp) only on the cycle frame_start=1; holds otherwise.
- moved = 1 on the cycle after a load whose new value differs from the previous latched value.
- Stage 1 (registered): hit_x = pix_x >= pos_latched && pix_x < pos_latched + SPRITE_W; hit_y = pix_y >= Y_POS && pix_y < Y_POS + SPRITE_H. Both computed 11 bits wide so the sum never wraps. Coordinates and pix_valid carried alongside.
- Stage 2 (registered): out_on = valid1 & hit_x & hit_y; out_color = out_on ? COLOR : 0; out_valid = valid1.
- No backpressure: every pix_valid cycle yields exactly one out_valid cycle two clocks later. Bubbles are preserved in order.
- Pixels with pix_x >= H_ACTIVE or pix_y >= V_ACTIVE always give out_on=0.

## Timing
- Latency pix_valid -> out_valid: exactly 2 cycles; throughput 1 pixel/cycle.
- frame_start and pix_valid in the same cycle: that pixel uses the old pos_latched. The new value applies from the next cycle.
- frame_start with x_pos changing the same cycle: the value sampled at that clock edge is taken.
- Reset values: pos_latched=0, moved=0, out_valid=0, out_on=0, out_x=0, out_y=0, out_color=0, pipeline valid bits 0.
- Reset mid-frame: pipeline flushed. out_valid stays 0 until 2 cycles after the first pix_valid following reset deassertion. pos_latched stays 0 until the next frame_start.
- x_pos change without frame_start: no effect on output.

## Configuration
- PLAYER_SPRITE_CLAMP_EN defined: x_pos > H_ACTIVE−SPRITE_W is latched as H_ACTIVE−SPRITE_W (608 at defaults), so the sprite is always fully visible.
- Undefined: raw x_pos is latched. The sprite is truncated at the right edge, and x_pos >= H_ACTIVE gives no visible pixels.
- moved compares post-clamp values in both builds.

## Structure
- Shared package player_pkg: COORD_W=10, COLOR_W=12, H_ACTIVE/V_ACTIVE defaults, and the rgb444_t typedef.
- One sub-module, sprite_range_cmp: a combinational 11-bit half-open range test (lo <= v < lo+len). It is instantiated twice, once for X and once for Y.
- The shadow register, moved logic and 2-stage pipeline stay in the top.

## Test plan
- Reset, then frame_start with x_pos=100; scan line 448 -> out_on=1 exactly for out_x 100..131, out_color=12'hF80; pos_latched=100, moved pulses once.
- Write x_pos=300 mid-frame without frame_start; scan line 450 -> sprite still at 100..131; after the next frame_start it is at 300..331.
- frame_start and pix_valid (x=100, y=448) in the same cycle, old pos=100, new x_pos=0 -> that pixel out_on=1; pixel x=100 on the next cycle -> out_on=0.
- x_pos=630, frame_start -> with PLAYER_SPRITE_CLAMP_EN, pos_latched=608 and on-pixels are 608..639. Without it, pos_latched=630, on-pixels are 630..639, and none are at x>=640.
- pix_valid pattern 1,0,1,1 -> out_valid 1,0,1,1 exactly 2 cycles later. Reset asserted mid-pattern -> out_valid=0 on the cycle after reset and all outputs 0.
- Same x_pos latched on two consecutive frame_starts -> moved stays 0 on the second.

Source files
------------

// File: rtl/player_pkg.sv
// Shared definitions for the player sprite path.
//   COORD_W   : pixel coordinate width
//   COLOR_W   : RGB 4:4:4 colour width
//   H_ACTIVE_DEF / V_ACTIVE_DEF : default visible raster size
//   rgb444_t  : colour word type
//   clamp_x() : saturate an X coordinate to an upper bound
package player_pkg;
  localparam int COORD_W      = 10;
  localparam int COLOR_W      = 12;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef logic [COLOR_W-1:0] rgb444_t;

  function automatic logic [COORD_W-1:0] clamp_x(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] max_x);
    return (x > max_x) ? max_x : x;
  endfunction
endpackage

// File: rtl/player_sprite_render_if.sv
// Pixel stream bundle between the raster timing source, the sprite
// renderer and the pixel mixer.
//   pix_*  : incoming pixel coordinate stream (master drives)
//   out_*  : rendered pixel stream, two cycles behind pix_* (slave drives)
// Stream semantics: a beat exists on every cycle its valid is high; there is
// no ready, so the consumer must accept every beat and bubbles (valid low)
// pass through in order.
interface player_sprite_render_if;
  import player_pkg::*;

  logic               pix_valid;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               out_valid;
  logic               out_on;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  rgb444_t            out_color;

  modport master (
    output pix_valid, pix_x, pix_y,
    input  out_valid, out_on, out_x, out_y, out_color
  );

  modport slave (
    input  pix_valid, pix_x, pix_y,
    output out_valid, out_on, out_x, out_y, out_color
  );
endinterface

// File: rtl/sprite_range_cmp.sv
// Combinational half-open range test: hit = (lo <= v < lo + len).
// Evaluated one bit wider than the operands so lo + len never wraps.
//   v   : coordinate under test
//   lo  : range start
//   len : range length
//   hit : v lies inside [lo, lo+len)
module sprite_range_cmp #(
  parameter int W = 10
) (
  input  logic [W-1:0] v,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] len,
  output logic         hit
);
  logic [W:0] v_e;
  logic [W:0] lo_e;
  logic [W:0] hi_e;

  assign v_e  = {1'b0, v};
  assign lo_e = {1'b0, lo};
  assign hi_e = {1'b0, lo} + {1'b0, len};
  assign hit  = (v_e >= lo_e) && (v_e < hi_e);
endmodule

// File: rtl/player_sprite_render.sv
// Player 1 sprite renderer. Latches the CPU-written X position at each frame
// boundary (so mid-frame writes never tear the sprite) and tests every pixel
// of the incoming stream against the player rectangle, producing a
// two-cycle-latency on-flag/colour stream for the pixel mixer.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   x_pos         : player X from the PIO register
//   frame_start   : one-cycle frame boundary pulse
//   pix           : pixel stream interface (slave modport)
//   pos_latched   : X position in use for the current frame
//   moved         : one-cycle pulse when the latched position changed
// Build option: define PLAYER_SPRITE_CLAMP_EN to saturate x_pos at
// H_ACTIVE-SPRITE_W so the sprite is always fully on screen.
module player_sprite_render
  import player_pkg::*;
#(
  parameter int      H_ACTIVE = H_ACTIVE_DEF,
  parameter int      V_ACTIVE = V_ACTIVE_DEF,
  parameter int      SPRITE_W = 32,
  parameter int      SPRITE_H = 16,
  parameter int      Y_POS    = 448,
  parameter rgb444_t COLOR    = 12'hF80
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COORD_W-1:0]   x_pos,
  input  logic                 frame_start,
  player_sprite_render_if.slave pix,
  output logic [COORD_W-1:0]   pos_latched,
  output logic                 moved
);
  localparam logic [COORD_W-1:0] SPR_W = COORD_W'(SPRITE_W);
  localparam logic [COORD_W-1:0] SPR_H = COORD_W'(SPRITE_H);
  localparam logic [COORD_W-1:0] Y_TOP = COORD_W'(Y_POS);
  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_ACTIVE);

  logic [COORD_W-1:0] pos_next;

`ifdef PLAYER_SPRITE_CLAMP_EN
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - SPRITE_W);
  assign pos_next = clamp_x(x_pos, X_MAX);
`else
  assign pos_next = x_pos;
`endif

  logic hit_x;
  logic hit_y;

  sprite_range_cmp #(.W(COORD_W)) u_cmp_x (
    .v   (pix.pix_x),
    .lo  (pos_latched),
    .len (SPR_W),
    .hit (hit_x)
  );

  sprite_range_cmp #(.W(COORD_W)) u_cmp_y (
    .v   (pix.pix_y),
    .lo  (Y_TOP),
    .len (SPR_H),
    .hit (hit_y)
  );

  // Stage 1 registers. The active-area test is folded into the hit bits so
  // an unclamped sprite hanging past the right edge never lights blanking.
  logic               valid1;
  logic               hit_x1;
  logic               hit_y1;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_latched   <= '0;
      moved         <= 1'b0;
      valid1        <= 1'b0;
      hit_x1        <= 1'b0;
      hit_y1        <= 1'b0;
      x1            <= '0;
      y1            <= '0;
      pix.out_valid <= 1'b0;
      pix.out_on    <= 1'b0;
      pix.out_x     <= '0;
      pix.out_y     <= '0;
      pix.out_color <= '0;
    end else begin
      // A pixel coinciding with frame_start still sees the old position:
      // the comparators read pos_latched before this edge updates it.
      if (frame_start) begin
        pos_latched <= pos_next;
      end
      moved <= frame_start && (pos_next != pos_latched);

      valid1 <= pix.pix_valid;
      hit_x1 <= hit_x && (pix.pix_x < H_LIM);
      hit_y1 <= hit_y && (pix.pix_y < V_LIM);
      x1     <= pix.pix_x;
      y1     <= pix.pix_y;

      pix.out_valid <= valid1;
      pix.out_on    <= valid1 && hit_x1 && hit_y1;
      pix.out_x     <= x1;
      pix.out_y     <= y1;
      pix.out_color <= (valid1 && hit_x1 && hit_y1) ? COLOR : '0;
    end
  end
endmodule

// File: tb/tb_player_sprite_render.sv
// Directed bench for player_sprite_render at default parameters.
// Expected values are hand-derived: sprite lines 448..463, width 32,
// colour F80, visible columns 0..639.
module tb_player_sprite_render;
  import player_pkg::*;

  localparam logic [11:0] SPR_COLOR = 12'hF80;

  // clock / reset
  logic clk;
  logic reset;
  logic [COORD_W-1:0] x_pos;
  logic frame_start;
  logic [COORD_W-1:0] pos_latched;
  logic moved;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  player_sprite_render_if psr_if ();

  player_sprite_render dut (
    .clk         (clk),
    .reset       (reset),
    .x_pos       (x_pos),
    .frame_start (frame_start),
    .pix         (psr_if.slave),
    .pos_latched (pos_latched),
    .moved       (moved)
  );

  int n_cmp;
  int n_err;

  // scoreboard: {valid, on, x, y, color}
  logic [33:0] exp_q[$];

  // driver tasks (inputs change on the falling edge)
  task automatic set_pix(input logic v, input int x, input int y);
    psr_if.pix_valid = v;
    psr_if.pix_x     = COORD_W'(x);
    psr_if.pix_y     = COORD_W'(y);
  endtask

  // Pulse frame_start for one cycle; returns on the falling edge where moved
  // and the new pos_latched are visible.
  task automatic frame_pulse(input int xp);
    @(negedge clk);
    x_pos       = COORD_W'(xp);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Drive one line segment and check every pixel two cycles later.
  task automatic scan_line(input string name, input int y, input int x_first,
                           input int x_last, input int on_lo, input int on_hi,
                           input bit line_hit);
    int n;
    logic [33:0] got;
    logic [33:0] exp;
    logic        e_on;
    n = x_last - x_first + 1;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        exp = exp_q.pop_front();
        got = {psr_if.out_valid, psr_if.out_on, psr_if.out_x, psr_if.out_y, psr_if.out_color};
        n_cmp++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL %s x=%0d: got %h expected %h", name, x_first + i - 2, got, exp);
        end
      end
      if (i < n) begin
        e_on = line_hit && (x_first + i >= on_lo) && (x_first + i <= on_hi);
        exp_q.push_back({1'b1, e_on, COORD_W'(x_first + i), COORD_W'(y),
                         e_on ? SPR_COLOR : 12'h000});
        set_pix(1'b1, x_first + i, y);
      end else begin
        set_pix(1'b0, 0, 0);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (psr_if.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s drain: out_valid got %b expected 0", name, psr_if.out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({psr_if.out_valid, psr_if.out_on, psr_if.out_x, psr_if.out_y, psr_if.out_color,
         pos_latched, moved} !== 45'd0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b on=%b x=%0d y=%0d c=%h pos=%0d moved=%b expected all 0",
               psr_if.out_valid, psr_if.out_on, psr_if.out_x, psr_if.out_y,
               psr_if.out_color, pos_latched, moved);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    frame_pulse(100);
    n_cmp++;
    if ({pos_latched, moved} !== {10'd100, 1'b1}) begin
      n_err++;
      $display("FAIL basic_latch: got pos=%0d moved=%b expected pos=100 moved=1", pos_latched, moved);
    end
    @(negedge clk);
    n_cmp++;
    if (moved !== 1'b0) begin
      n_err++;
      $display("FAIL basic_moved_pulse: got moved=%b expected 0", moved);
    end
    scan_line("basic_scan", 448, 90, 140, 100, 131, 1'b1);
  endtask

  task automatic test_no_tear();
    @(negedge clk);
    x_pos = 10'd300;
    scan_line("no_tear_old", 450, 95, 135, 100, 131, 1'b1);
    n_cmp++;
    if ({pos_latched, moved} !== {10'd100, 1'b0}) begin
      n_err++;
      $display("FAIL no_tear_hold: got pos=%0d moved=%b expected pos=100 moved=0", pos_latched, moved);
    end
    frame_pulse(300);
    n_cmp++;
    if ({pos_latched, moved} !== {10'd300, 1'b1}) begin
      n_err++;
      $display("FAIL no_tear_latch: got pos=%0d moved=%b expected pos=300 moved=1", pos_latched, moved);
    end
    scan_line("no_tear_new", 450, 290, 340, 300, 331, 1'b1);
  endtask

  task automatic test_same_cycle();
    frame_pulse(100);
    @(negedge clk);
    x_pos       = 10'd0;
    frame_start = 1'b1;
    set_pix(1'b1, 100, 448);
    @(negedge clk);
    frame_start = 1'b0;
    set_pix(1'b1, 100, 448);
    n_cmp++;
    if ({pos_latched, moved} !== {10'd0, 1'b1}) begin
      n_err++;
      $display("FAIL same_cycle_latch: got pos=%0d moved=%b expected pos=0 moved=1", pos_latched, moved);
    end
    @(negedge clk);
    set_pix(1'b0, 0, 0);
    n_cmp++;
    if ({psr_if.out_valid, psr_if.out_on, psr_if.out_x, psr_if.out_color} !== {1'b1, 1'b1, 10'd100, SPR_COLOR}) begin
      n_err++;
      $display("FAIL same_cycle_old_pos: got v=%b on=%b x=%0d c=%h expected v=1 on=1 x=100 c=f80",
               psr_if.out_valid, psr_if.out_on, psr_if.out_x, psr_if.out_color);
    end
    @(negedge clk);
    n_cmp++;
    if ({psr_if.out_valid, psr_if.out_on, psr_if.out_x, psr_if.out_color} !== {1'b1, 1'b0, 10'd100, 12'h000}) begin
      n_err++;
      $display("FAIL same_cycle_new_pos: got v=%b on=%b x=%0d c=%h expected v=1 on=0 x=100 c=000",
               psr_if.out_valid, psr_if.out_on, psr_if.out_x, psr_if.out_color);
    end
  endtask

  task automatic test_right_edge();
    int exp_pos;
`ifdef PLAYER_SPRITE_CLAMP_EN
    exp_pos = 608;
`else
    exp_pos = 630;
`endif
    frame_pulse(630);
    n_cmp++;
    if ({pos_latched, moved} !== {COORD_W'(exp_pos), 1'b1}) begin
      n_err++;
      $display("FAIL edge_latch: got pos=%0d moved=%b expected pos=%0d moved=1", pos_latched, moved, exp_pos);
    end
    scan_line("edge_scan", 448, 600, 665, exp_pos, 639, 1'b1);
    scan_line("edge_off_line", 440, 620, 625, exp_pos, 639, 1'b0);
    scan_line("edge_below", 464, 630, 633, exp_pos, 639, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        n_cmp++;
        if (psr_if.out_valid !== pat[i-2]) begin
          n_err++;
          $display("FAIL bubble_%0d: out_valid got %b expected %b", i - 2, psr_if.out_valid, pat[i-2]);
        end
      end
      if (i < 4) set_pix(pat[i], 620 + i, 448);
      else       set_pix(1'b0, 0, 0);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_pix(1'b1, 620, 448);
    @(negedge clk);
    set_pix(1'b1, 621, 448);
    @(negedge clk);
    reset = 1'b1;
    set_pix(1'b1, 622, 448);
    @(negedge clk);
    n_cmp++;
    if ({psr_if.out_valid, psr_if.out_on, psr_if.out_x, psr_if.out_y, psr_if.out_color,
         pos_latched, moved} !== 45'd0) begin
      n_err++;
      $display("FAIL reset_mid_flush: got v=%b on=%b x=%0d y=%0d c=%h pos=%0d moved=%b expected all 0",
               psr_if.out_valid, psr_if.out_on, psr_if.out_x, psr_if.out_y,
               psr_if.out_color, pos_latched, moved);
    end
    reset = 1'b0;
    set_pix(1'b0, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (psr_if.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_idle: out_valid got %b expected 0", psr_if.out_valid);
    end
    set_pix(1'b1, 625, 448);
    @(negedge clk);
    set_pix(1'b0, 0, 0);
    n_cmp++;
    if (psr_if.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_lat1: out_valid got %b expected 0", psr_if.out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if ({psr_if.out_valid, psr_if.out_on, psr_if.out_x, pos_latched} !== {1'b1, 1'b0, 10'd625, 10'd0}) begin
      n_err++;
      $display("FAIL reset_mid_first: got v=%b on=%b x=%0d pos=%0d expected v=1 on=0 x=625 pos=0",
               psr_if.out_valid, psr_if.out_on, psr_if.out_x, pos_latched);
    end
  endtask

  task automatic test_same_pos();
    frame_pulse(50);
    n_cmp++;
    if ({pos_latched, moved} !== {10'd50, 1'b1}) begin
      n_err++;
      $display("FAIL same_pos_first: got pos=%0d moved=%b expected pos=50 moved=1", pos_latched, moved);
    end
    frame_pulse(50);
    n_cmp++;
    if ({pos_latched, moved} !== {10'd50, 1'b0}) begin
      n_err++;
      $display("FAIL same_pos_second: got pos=%0d moved=%b expected pos=50 moved=0", pos_latched, moved);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b1;
    x_pos       = '0;
    frame_start = 1'b0;
    set_pix(1'b0, 0, 0);

    test_reset();
    test_basic();
    test_no_tear();
    test_same_cycle();
    test_right_edge();
    test_back_to_back();
    test_reset_mid();
    test_same_pos();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
